// File: rtl/dot_product_acc_pkg.sv
// Shared types and helpers for the streaming dot-product engine.
package dot_product_acc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_e;

  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/dot_product_acc_mac.sv
// Per-beat lane products: multiply, rescale, sign-extend, reduce.
module mac_lane_tree
  import dot_product_acc_pkg::*;
#(
  parameter int bitwidth      = 32,
  parameter int inputBitwidth = 16,
  parameter int fracBitwidth  = 7,
  parameter int SIZE          = 4
) (
  input  logic [SIZE*inputBitwidth-1:0] x_in,
  input  logic [SIZE*inputBitwidth-1:0] w_in,
  output logic [bitwidth-1:0]           chunk_sum
);

  localparam int IW = inputBitwidth;

  logic [bitwidth-1:0] lane_p [SIZE];

  for (genvar i = 0; i < SIZE; i++) begin : g_lane
    logic signed [IW-1:0]   xs;
    logic signed [IW-1:0]   ws;
    logic signed [2*IW-1:0] prod;
    logic signed [2*IW-1:0] shf;

    assign xs   = x_in[lane_lsb(i, IW) +: IW];
    assign ws   = w_in[lane_lsb(i, IW) +: IW];
    assign prod = xs * ws;
    // arithmetic shift floors toward -inf
    assign shf  = prod >>> fracBitwidth;
    assign lane_p[i] = bitwidth'(shf);
  end

  always_comb begin
    chunk_sum = '0;
    for (int i = 0; i < SIZE; i++) begin
      chunk_sum = chunk_sum + lane_p[i];
    end
  end

endmodule

// File: rtl/dot_product_acc.sv
// Streaming fixed-point dot-product engine: NUM_CHUNK beats of
// SIZE pairs summed into one sample result with valid/ready output.
module dot_product_acc
  import dot_product_acc_pkg::*;
#(
  parameter int bitwidth      = 32,
  parameter int inputBitwidth = 16,
  parameter int fracBitwidth  = 7,
  parameter int SIZE          = 4,
  parameter int NUM_CHUNK     = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [SIZE*inputBitwidth-1:0] x_in,
  input  logic [SIZE*inputBitwidth-1:0] w_in,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [bitwidth-1:0]           data_out,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          busy
);

  localparam int CW = cnt_width(NUM_CHUNK);
  localparam logic [CW-1:0] LAST = CW'(NUM_CHUNK - 1);

  state_e              state_q, state_d;
  logic [bitwidth-1:0] acc_q, acc_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [bitwidth-1:0] dout_q, dout_d;
  logic                ov_q, ov_d;
  logic [bitwidth-1:0] chunk_sum;
  logic                beat;

  mac_lane_tree #(
    .bitwidth      (bitwidth),
    .inputBitwidth (inputBitwidth),
    .fracBitwidth  (fracBitwidth),
    .SIZE          (SIZE)
  ) u_tree (
    .x_in      (x_in),
    .w_in      (w_in),
    .chunk_sum (chunk_sum)
  );

  assign in_ready  = (state_q == ACC);
  assign busy      = (state_q != IDLE);
  assign data_out  = dout_q;
  assign out_valid = ov_q;
  assign beat      = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    ov_d    = ov_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ACC;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      ACC: begin
        if (beat) begin
          if (cnt_q == LAST) begin
            dout_d  = acc_q + chunk_sum;
            ov_d    = 1'b1;
            state_d = HOLD;
          end else begin
            acc_d = acc_q + chunk_sum;
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      HOLD: begin
        if (ov_q && out_ready) begin
          ov_d = 1'b0;
          // start on the handshake cycle skips the idle bubble
          if (start) begin
            state_d = ACC;
            acc_d   = '0;
            cnt_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      ov_q    <= ov_d;
    end
  end

endmodule

// File: tb/tb_dot_product_acc.sv
// Directed bench for dot_product_acc: default config plus
// NUM_CHUNK=1024 (wrap) and NUM_CHUNK=1 instances.
module tb_dot_product_acc;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;

  logic        rst_n, start, in_valid, out_ready;
  logic [63:0] x_in, w_in;
  logic        in_ready, out_valid, busy;
  logic [31:0] data_out;

  logic        rst1_n, start1, iv1, ordy1;
  logic [63:0] x1, w1;
  logic        ir1, ov1, busy1;
  logic [31:0] do1;

  logic        start2, iv2, ordy2;
  logic        ir2, ov2, busy2;
  logic [31:0] do2;

  dot_product_acc dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .x_in      (x_in),
    .w_in      (w_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_out  (data_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  dot_product_acc #(.NUM_CHUNK(1024)) dut_big (
    .clk       (clk),
    .rst_n     (rst1_n),
    .start     (start1),
    .x_in      (x1),
    .w_in      (w1),
    .in_valid  (iv1),
    .in_ready  (ir1),
    .data_out  (do1),
    .out_valid (ov1),
    .out_ready (ordy1),
    .busy      (busy1)
  );

  dot_product_acc #(.NUM_CHUNK(1)) dut_one (
    .clk       (clk),
    .rst_n     (rst1_n),
    .start     (start2),
    .x_in      (x1),
    .w_in      (w1),
    .in_valid  (iv2),
    .in_ready  (ir2),
    .data_out  (do2),
    .out_valid (ov2),
    .out_ready (ordy2),
    .busy      (busy2)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic beats(input int n, input logic [15:0] x,
                       input logic [15:0] w, input bit gap);
    x_in = {4{x}};
    w_in = {4{w}};
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      @(negedge clk);
      if (gap) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag, input logic [31:0] exp);
    int n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_ov"}, out_valid, 1'b1);
    if (out_valid) chk(tag, data_out, exp);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 0; start = 0; in_valid = 0; out_ready = 0;
    x_in = '0; w_in = '0;
    rst1_n = 0; start1 = 0; iv1 = 0; ordy1 = 0;
    start2 = 0; iv2 = 0; ordy2 = 0;
    x1 = '0; w1 = '0;
    @(negedge clk);
    chk("rst_dout", data_out, 32'd0);
    chk("rst_ov", out_valid, 1'b0);
    chk("rst_ir", in_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst_n = 1; rst1_n = 1;
    @(negedge clk);

    // 1: 1.0*1.0 on 4 lanes, 8 beats -> 4096
    pulse_start();
    chk("t1_busy", busy, 1'b1);
    chk("t1_ir", in_ready, 1'b1);
    beats(7, 16'd128, 16'd128, 1'b0);
    chk("t1_ov_early", out_valid, 1'b0);
    beats(1, 16'd128, 16'd128, 1'b0);
    chk("t1_ov_lat", out_valid, 1'b1);
    chk("t1_ir_hold", in_ready, 1'b0);
    wait_out("t1_sum", 32'd4096);
    chk("t1_idle", busy, 1'b0);

    // 2: -1.0*0.5 = -64 per lane, gapped beats -> 4*8*-64
    pulse_start();
    beats(7, 16'hFF80, 16'd64, 1'b1);
    chk("t2_ov_early", out_valid, 1'b0);
    beats(1, 16'hFF80, 16'd64, 1'b1);
    wait_out("t2_sum", 32'hFFFF_F800);

    // 3: stall in HOLD, stray in_valid/start ignored
    pulse_start();
    beats(8, 16'd256, 16'd128, 1'b0);
    start = 1'b1; in_valid = 1'b1; x_in = {4{16'd999}};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_dout", data_out, 32'd8192);
      chk("t3_ov", out_valid, 1'b1);
      chk("t3_ir", in_ready, 1'b0);
    end
    start = 1'b0; in_valid = 1'b0;
    wait_out("t3_sum", 32'd8192);

    // 4: handshake + start same cycle, then floor of -1*1 per lane
    pulse_start();
    beats(8, 16'd384, 16'd128, 1'b0);
    chk("t4_first", data_out, 32'd12288);
    out_ready = 1'b1; start = 1'b1;
    @(negedge clk);
    out_ready = 1'b0; start = 1'b0;
    chk("t4_ov_drop", out_valid, 1'b0);
    chk("t4_ir_b2b", in_ready, 1'b1);
    beats(8, 16'hFFFF, 16'd1, 1'b0);
    wait_out("t4_second", 32'hFFFF_FFE0);

    // 5: async reset mid-sample
    pulse_start();
    beats(3, 16'd128, 16'd128, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_dout", data_out, 32'd0);
    chk("t5_ov", out_valid, 1'b0);
    chk("t5_ir", in_ready, 1'b0);
    chk("t5_busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pulse_start();
    beats(8, 16'd128, 16'd64, 1'b0);
    wait_out("t5_sum", 32'd2048);

    // NUM_CHUNK=1: single beat goes straight to HOLD
    x1 = {4{16'd128}}; w1 = {4{16'd128}};
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0; iv2 = 1'b1;
    @(negedge clk);
    iv2 = 1'b0;
    chk("nc1_ov", ov2, 1'b1);
    chk("nc1_sum", do2, 32'd512);

    // 6: 1024 beats of 0x7FFF^2 -> (2^25-2^11)*2^10 mod 2^32
    x1 = {4{16'h7FFF}}; w1 = {4{16'h7FFF}};
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0; iv1 = 1'b1;
    for (int i = 0; i < 1023; i++) @(negedge clk);
    chk("t6_ov_early", ov1, 1'b0);
    @(negedge clk);
    iv1 = 1'b0;
    chk("t6_ov", ov1, 1'b1);
    chk("t6_wrap", do1, 32'hFFE0_0000);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
